rx_parity_engine: RTL
=====================

Name: rx_parity_engine

Overview:
Next-generation UART receive parity engine. It sits between the Rx bit sampler and the Rx frame logic. It accumulates parity serially from sampled data bits and deserialises the data word LSB-first. It checks the received parity bit against a run-time selectable parity mode, and keeps a sticky error flag and a saturating error counter that software can clear.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
ERR_CNT_WIDTH, 8, width of the saturating parity-error counter; minimum 2.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
serial_in_synced  input  1  synchronised Rx line, sampled only when bit_strobe=1.
bit_strobe  input  1  one-cycle pulse at the mid-bit sample point.
frame_start  input  1  one-cycle pulse when a valid start bit is confirmed.
parity_mode  input  3  000 none, 001 even, 010 odd, 011 mark, 100 space; 101..111 treated as none.
error_clear  input  1  one-cycle pulse; clears the sticky flag and the counter.
frame_active  output  1  high while in DATA or PARITY state.
result_valid  output  1  one-cycle pulse; data_out and rx_error are valid.
data_out  output  DATA_WIDTH  deserialised word, held until the next result_valid.
rx_error  output  1  parity mismatch for this frame; qualified by result_valid.
parity_error_sticky  output  1  set on any parity error; held until error_clear.
error_count  output  ERR_CNT_WIDTH  number of parity errors, saturating at all-ones.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; parity accumulator 0; bit counter 0; latched mode = none.
- States:
  - IDLE: frame_start -> DATA. On entry to DATA: latch parity_mode, clear accumulator, clear bit counter, clear the shift register.
  - DATA: each bit_strobe does three things: acc <= acc ^ serial_in_synced; shift register shifts right with the new bit entering the MSB (LSB-first); counter increments. When the DATA_WIDTH-th strobe is taken:
    - latched mode is none -> DONE, rx_error=0;
    - otherwise -> PARITY.
  - PARITY: the next bit_strobe compares the sampled bit p with the expected value, registers the error, then -> DONE. Expected value by mode:
    - even: acc;
    - odd: ~acc;
    - mark: 1;
    - space: 0.
    - error = (p != expected).
  - DONE: one cycle. result_valid=1, data_out updated, rx_error = the error result; then -> IDLE.
- Latency: result_valid asserts exactly 1 cycle after the final consumed strobe (the parity strobe, or the last data strobe in none mode).
- rx_error is 0 whenever result_valid=0.
- data_out, error_count and parity_error_sticky hold their values between events.
- parity_mode changes during a frame have no effect; only the value latched at frame start is used.
- frame_start in DATA, PARITY or DONE aborts the current frame and restarts DATA with a fresh latch. No result_valid is produced for the aborted frame.
- frame_start and bit_strobe in the same cycle: frame_start wins; the strobe is ignored.
- bit_strobe in IDLE or DONE is ignored.
- Sticky flag and counter are updated in the DONE cycle when rx_error=1. The counter increments by 1 and stays at all-ones once there.
- error_clear in the same cycle as a new error: the clear applies first, then the error. Result: sticky=1, count=1.
- Reset asserted mid-frame: immediate return to IDLE; no result; counter and sticky cleared.

Test Plan:
1. Even mode, DATA_WIDTH=8, frame 0x55 LSB-first, parity bit 0 -> result_valid 1 cycle after the parity strobe; data_out=0x55; rx_error=0; count=0.
2. Even mode, 0x55, parity bit 1 -> rx_error=1 with valid; sticky=1; count=1. Same data in odd mode with parity bit 1 -> rx_error=0.
3. Mark mode with parity bit 0 -> error. Space mode with parity bit 0 -> no error. Mode 111 on 0xA3 -> valid 1 cycle after the 8th data strobe; rx_error=0; no PARITY state.
4. ERR_CNT_WIDTH=2: five erroneous frames -> count 1,2,3,3,3; sticky=1. error_clear coincident with the 6th error -> count=1, sticky=1.
5. frame_start after 4 data strobes -> no valid for the old frame. A new full frame 0x0F with even parity bit 0 -> data_out=0x0F, rx_error=0.
6. reset low during PARITY with count=2 -> state IDLE; all outputs 0 the same cycle (asynchronous). After release, the next good frame reports normally.

Source files
------------

// File: rtl/rx_parity_engine.sv
// UART receive parity engine: deserialises data bits LSB-first, accumulates
// parity serially, checks the parity bit and tracks parity errors.
module rx_parity_engine #(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     serial_in_synced,
    input  logic                     bit_strobe,
    input  logic                     frame_start,
    input  logic [2:0]               parity_mode,
    input  logic                     error_clear,
    output logic                     frame_active,
    output logic                     result_valid,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     rx_error,
    output logic                     parity_error_sticky,
    output logic [ERR_CNT_WIDTH-1:0] error_count
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        MODE_NONE  = 3'b000,
        MODE_EVEN  = 3'b001,
        MODE_ODD   = 3'b010,
        MODE_MARK  = 3'b011,
        MODE_SPACE = 3'b100
    } mode_t;

    state_t                state, state_nxt;
    mode_t                 mode_q;
    logic                  acc;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic                  err_q;
    logic                  take_data;
    logic                  take_parity;
    logic                  last_data;
    logic                  expected_parity;

    // Codes 101..111 collapse to "none" so the rest of the logic sees five modes.
    function automatic mode_t decode_mode(input logic [2:0] raw);
        case (raw)
            3'b001:  return MODE_EVEN;
            3'b010:  return MODE_ODD;
            3'b011:  return MODE_MARK;
            3'b100:  return MODE_SPACE;
            default: return MODE_NONE;
        endcase
    endfunction

    // frame_start outranks a coincident strobe, so strobes are only taken without it.
    assign take_data   = (state == S_DATA)   && bit_strobe && !frame_start;
    assign take_parity = (state == S_PARITY) && bit_strobe && !frame_start;
    assign last_data   = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
    assign shift_nxt   = {serial_in_synced, shift_reg[DATA_WIDTH-1:1]};

    always_comb begin
        case (mode_q)
            MODE_EVEN:  expected_parity = acc;
            MODE_ODD:   expected_parity = ~acc;
            MODE_MARK:  expected_parity = 1'b1;
            default:    expected_parity = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent logic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (frame_start) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (frame_start) begin
                    state_nxt = S_DATA;
                end else if (take_data && last_data) begin
                    state_nxt = (mode_q == MODE_NONE) ? S_DONE : S_PARITY;
                end
            end
            S_PARITY: begin
                if (frame_start)      state_nxt = S_DATA;
                else if (take_parity) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = frame_start ? S_DATA : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q    <= MODE_NONE;
            acc       <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            err_q     <= 1'b0;
            data_out  <= '0;
        end else if (frame_start) begin
            mode_q    <= decode_mode(parity_mode);
            acc       <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            err_q     <= 1'b0;
        end else if (take_data) begin
            acc       <= acc ^ serial_in_synced;
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_cnt + 1'b1;
            // Without parity the frame completes on this strobe.
            if (last_data && mode_q == MODE_NONE) begin
                err_q    <= 1'b0;
                data_out <= shift_nxt;
            end
        end else if (take_parity) begin
            err_q    <= (serial_in_synced != expected_parity);
            data_out <= shift_reg;
        end
    end

    assign frame_active = (state == S_DATA) || (state == S_PARITY);
    assign result_valid = (state == S_DONE);
    assign rx_error     = (state == S_DONE) && err_q;

    // A clear coinciding with a new error wipes history first, then records the error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_error_sticky <= 1'b0;
            error_count         <= '0;
        end else if (error_clear) begin
            parity_error_sticky <= rx_error;
            error_count         <= ERR_CNT_WIDTH'(rx_error);
        end else if (rx_error) begin
            parity_error_sticky <= 1'b1;
            if (error_count != '1) error_count <= error_count + 1'b1;
        end
    end

endmodule
